// File: rtl/de2i150_core_pio_blink_if.sv
// Avalon-MM slave bus bundle for the blinking output PIO.
interface de2i150_core_pio_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );
endinterface

// File: rtl/de2i150_core_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear, per-bit blinking driven by a
// programmable prescaler, and a registered (latency 1) read path.
module de2i150_core_pio_blink #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           PERIOD_WIDTH = 24,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
   parameter int unsigned           RESET_PERIOD = 25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   de2i150_core_pio_blink_if.slave bus,
   output logic [DATA_WIDTH-1:0]   out_port
);

   localparam logic [2:0] AddrData   = 3'd0;
   localparam logic [2:0] AddrBlink  = 3'd1;
   localparam logic [2:0] AddrPeriod = 3'd2;
   localparam logic [2:0] AddrCtrl   = 3'd3;
   localparam logic [2:0] AddrSet    = 3'd4;
   localparam logic [2:0] AddrClear  = 3'd5;
   localparam logic [2:0] AddrStatus = 3'd6;

   localparam logic [PERIOD_WIDTH-1:0] PeriodInit = PERIOD_WIDTH'(RESET_PERIOD);

   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   blink_q, blink_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    en_q, en_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;

   logic                    wr_en, rd_en, run, terminal;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [PERIOD_WIDTH-1:0] wr_period;
   logic [31:0]             rd_val;

   assign wr_en     = bus.chipselect & ~bus.write_n;
   // A write wins over a simultaneous read; readdata then holds.
   assign rd_en     = bus.chipselect & ~bus.read_n & bus.write_n;
   assign wr_data   = bus.writedata[DATA_WIDTH-1:0];
   assign wr_period = bus.writedata[PERIOD_WIDTH-1:0];
   assign run       = en_q & (period_q != '0);
   assign terminal  = (cnt_q == period_q);

   // Register file write decode, including atomic set/clear of DATA.
   always_comb begin
      data_d   = data_q;
      blink_d  = blink_q;
      period_d = period_q;
      en_d     = en_q;
      if (wr_en) begin
         case (bus.address)
            AddrData:   data_d   = wr_data;
            AddrBlink:  blink_d  = wr_data;
            AddrPeriod: period_d = wr_period;
            AddrCtrl:   en_d     = bus.writedata[0];
            AddrSet:    data_d   = data_q | wr_data;
            AddrClear:  data_d   = data_q & ~wr_data;
            default:    ;
         endcase
      end
   end

   // Prescaler: free-running compare counter, with bus writes overriding it.
   always_comb begin
      cnt_d   = '0;
      phase_d = 1'b1;
      if (run) begin
         if (terminal) begin
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + PERIOD_WIDTH'(1);
            phase_d = phase_q;
         end
      end
      if (wr_en && bus.address == AddrPeriod) begin
         // New period restarts the count without toggling the phase.
         cnt_d   = '0;
         phase_d = run ? phase_q : 1'b1;
      end else if (wr_en && bus.address == AddrCtrl && !bus.writedata[0]) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end
   end

   // Readback mux; unused upper bits are zero.
   always_comb begin
      rd_val = '0;
      case (bus.address)
         AddrData:   rd_val[DATA_WIDTH-1:0]   = data_q;
         AddrBlink:  rd_val[DATA_WIDTH-1:0]   = blink_q;
         AddrPeriod: rd_val[PERIOD_WIDTH-1:0] = period_q;
         AddrCtrl:   rd_val[1:0]              = {phase_q, en_q};
         AddrStatus: rd_val[DATA_WIDTH-1:0]   = out_port;
         default:    rd_val = '0;
      endcase
      readdata_d = rd_en ? rd_val : readdata_q;
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q     <= RESET_VALUE;
         blink_q    <= '0;
         period_q   <= PeriodInit;
         en_q       <= 1'b0;
         cnt_q      <= '0;
         phase_q    <= 1'b1;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         blink_q    <= blink_d;
         period_q   <= period_d;
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
      end
   end

   // Pins come straight from registers, never through the bus mux.
   assign out_port     = data_q & ~(blink_q & {DATA_WIDTH{~phase_q}});
   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_de2i150_core_pio_blink.sv
// Directed bench for the blinking output PIO. Bus inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
module tb_de2i150_core_pio_blink;

   logic        clk;
   logic        reset;
   logic [31:0] out_port;
   logic [31:0] rd;
   int          n_checks;
   int          n_errors;

   de2i150_core_pio_blink_if bus ();

   // 25000000 needs 25 bits, so the period register is widened here.
   de2i150_core_pio_blink #(
      .DATA_WIDTH   (32),
      .PERIOD_WIDTH (25),
      .RESET_VALUE  (32'h0000_00FF),
      .RESET_PERIOD (25000000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b1;
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = addr;
      bus.writedata  = data;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      bus.address    = addr;
      @(negedge clk);
      data = bus.readdata;
      bus_idle();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      reset         = 1'b1;
      bus.address   = '0;
      bus.writedata = '0;
      bus_idle();

      // 1. Reset values
      idle(3);
      check_eq("rst_out_during", out_port, 32'h0000_00FF);
      reset = 1'b0;
      check_eq("rst_readdata", bus.readdata, 32'h0);
      bus_read(3'd0, rd); check_eq("rst_data", rd, 32'h0000_00FF);
      bus_read(3'd1, rd); check_eq("rst_mask", rd, 32'h0);
      bus_read(3'd2, rd); check_eq("rst_period", rd, 32'd25000000);
      bus_read(3'd3, rd); check_eq("rst_ctrl", rd, 32'h2);

      // 2. Set/clear and read latency
      bus_write(3'd0, 32'hA5A5_0000);
      bus_write(3'd4, 32'h0000_000F);
      bus_write(3'd5, 32'hA000_0000);
      check_eq("setclr_out", out_port, 32'h05A5_000F);
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      bus.address    = 3'd6;
      #1;
      check_eq("rd_not_comb", bus.readdata, 32'h2);
      @(negedge clk);
      check_eq("rd_status_lat1", bus.readdata, 32'h05A5_000F);
      bus_idle();
      bus_read(3'd4, rd); check_eq("rd_outset", rd, 32'h0);
      bus_read(3'd5, rd); check_eq("rd_outclear", rd, 32'h0);
      bus_read(3'd6, rd); check_eq("rd_status", rd, 32'h05A5_000F);
      // Read and write together: write lands, readdata holds.
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      bus.write_n    = 1'b0;
      bus.address    = 3'd0;
      bus.writedata  = 32'h1234_5678;
      @(negedge clk);
      bus_idle();
      check_eq("rdwr_hold", bus.readdata, 32'h05A5_000F);
      check_eq("rdwr_write", out_port, 32'h1234_5678);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd7, rd); check_eq("rd_reserved", rd, 32'h0);
      check_eq("wr_reserved", out_port, 32'h1234_5678);

      // 3. Blink timing: 4 clks of 0xFF then 4 clks of 0xF0
      bus_write(3'd2, 32'd3);
      bus_write(3'd1, 32'hF);
      bus_write(3'd0, 32'hFF);
      bus_write(3'd3, 32'h1);
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("blink_%0d", i), out_port, ((i / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
         @(negedge clk);
      end
      // Phase 1, counter 0 here.
      bus_read(3'd3, rd); check_eq("blink_ctrl", rd, 32'h3);

      // 4. PERIOD write on the terminal cycle: no toggle, next toggle 6 clks on
      idle(2);
      bus_write(3'd2, 32'd5);
      for (int j = 0; j < 12; j++) begin
         check_eq($sformatf("perwr_%0d", j), out_port, (j < 6) ? 32'hFF : 32'hF0);
         @(negedge clk);
      end
      // Counter is at 0 with phase 1; terminal (phase 1) is 5 clks away.
      idle(5);
      check_eq("ctrl0_pre", out_port, 32'hFF);
      bus_write(3'd3, 32'h0);
      for (int k = 0; k < 20; k++) begin
         check_eq($sformatf("ctrl0_%0d", k), out_port, 32'hFF);
         @(negedge clk);
      end
      bus_read(3'd3, rd); check_eq("ctrl0_ctrl", rd, 32'h2);

      // 5. PERIOD=0 with en=1 holds phase 1
      bus_write(3'd2, 32'd0);
      bus_write(3'd3, 32'h1);
      for (int k = 0; k < 100; k++) begin
         check_eq($sformatf("per0_%0d", k), out_port, 32'hFF);
         @(negedge clk);
      end
      bus_read(3'd3, rd); check_eq("per0_ctrl", rd, 32'h3);

      // 6. Asynchronous reset during phase 0
      bus_write(3'd2, 32'd3);
      idle(5);
      check_eq("arst_pre", out_port, 32'hF0);
      bus_write(3'd0, 32'h0000_AAF0);
      check_eq("arst_pre2", out_port, 32'h0000_AAF0);
      #1 reset = 1'b1;
      #1 check_eq("arst_immediate", out_port, 32'h0000_00FF);
      idle(3);
      reset = 1'b0;
      bus_read(3'd3, rd); check_eq("arst_ctrl", rd, 32'h2);
      bus_read(3'd1, rd); check_eq("arst_mask", rd, 32'h0);
      bus_read(3'd2, rd); check_eq("arst_period", rd, 32'd25000000);
      bus_write(3'd1, 32'hF);
      for (int k = 0; k < 20; k++) begin
         check_eq($sformatf("arst_hold_%0d", k), out_port, 32'hFF);
         @(negedge clk);
      end
      bus_read(3'd3, rd); check_eq("arst_ctrl2", rd, 32'h2);
      bus_read(3'd0, rd); check_eq("arst_data", rd, 32'h0000_00FF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
